slc3_mem_responder: RTL and testbench

Memory-side responder for the SLC-3 CPU's memory bus. It accepts read (OE) and write (WE) requests on ADDR, inserts a programmable number of wait states, and services the request from an internal single-port RAM. It returns read data with a one-cycle Ready pulse. Address IO_ADDR is memory-mapped I/O: reads return the synchronized switches, writes load the hex-display register. The block sits between slc3 and the board I/O and replaces the zero-latency test memory.

---
 rtl/slc3_mem_pkg.sv | 19 +
 rtl/slc3_ram_sp.sv | 21 ++
 rtl/sync.sv | 21 ++
 rtl/slc3_mem_responder.sv | 120 ++++++++++++
 tb/tb_slc3_mem_responder.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory-side responder.
package slc3_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE,
        RELEASE
    } mem_state_t;

    typedef enum logic {
        READ,
        WRITE
    } mem_op_t;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/slc3_ram_sp.sv
// Single-port synchronous 16-bit RAM with one-cycle read latency and no reset.
module slc3_ram_sp #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata
);

    logic [15:0] mem [0:(1 << DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: wait-state insertion, single-port RAM and
// memory-mapped switch/hex I/O at IO_ADDR, with a one-cycle Ready pulse.
module slc3_mem_responder
    import slc3_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_to_SRAM,
    input  logic        OE,
    input  logic        WE,
    output logic [15:0] Data_from_SRAM,
    output logic        Ready,
    input  logic [9:0]  SW,
    output logic [15:0] HEX_data,
    output logic        Collision
);

    mem_state_t            state, state_next;
    mem_op_t               req_op;
    logic [15:0]           req_addr;
    logic [15:0]           req_data;
    logic [3:0]            wait_cnt;
    logic [9:0]            sw_s;
    logic                  io_hit;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [15:0]           ram_rdata;

    for (genvar i = 0; i < 10; i++) begin : g_sw_sync
        sync u_sync (
            .clk  (Clk),
            .rst_n(Reset_n),
            .d    (SW[i]),
            .q    (sw_s[i])
        );
    end

    assign io_hit = (req_addr == IO_ADDR);
    assign ram_we = (state == ACCESS) && (req_op == WRITE) && !io_hit;
    // In IDLE the RAM is addressed straight from ADDR so the read word is
    // already on ram_rdata during ACCESS, even with zero wait states.
    assign ram_addr = (state == IDLE) ? ADDR[DEPTH_LOG2-1:0]
                                      : req_addr[DEPTH_LOG2-1:0];
    assign Ready    = (state == DONE);

    slc3_ram_sp #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk  (Clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(req_data),
        .rdata(ram_rdata)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (OE || WE) state_next = (WAIT_STATES != 0) ? WAIT : ACCESS;
            WAIT:    if (wait_cnt <= 4'd1) state_next = ACCESS;
            ACCESS:  state_next = DONE;
            DONE:    state_next = RELEASE;
            RELEASE: if (!OE && !WE) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            req_addr       <= '0;
            req_data       <= '0;
            req_op         <= READ;
            wait_cnt       <= '0;
            Data_from_SRAM <= '0;
            HEX_data       <= '0;
            Collision      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (OE || WE) begin
                        req_addr <= ADDR;
                        req_data <= Data_to_SRAM;
                        req_op   <= WE ? WRITE : READ;
                        wait_cnt <= 4'(WAIT_STATES);
                        if (OE && WE) begin
                            Collision <= 1'b1;
                        end
                    end
                end
                WAIT: wait_cnt <= wait_cnt - 4'd1;
                ACCESS: begin
                    if (req_op == WRITE) begin
                        if (io_hit) begin
                            HEX_data <= req_data;
                        end
                    end else if (io_hit) begin
                        Data_from_SRAM <= {6'b0, sw_s};
                    end else begin
                        Data_from_SRAM <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Directed self-checking bench for slc3_mem_responder (default and zero-wait builds).
module tb_slc3_mem_responder;

    logic        Clk;
    logic        Reset_n;
    logic [9:0]  SW;

    logic [15:0] ADDR, Data_to_SRAM;
    logic        OE, WE;
    logic [15:0] Data_from_SRAM, HEX_data;
    logic        Ready, Collision;

    logic [15:0] ADDR0, Data_to_SRAM0;
    logic        OE0, WE0;
    logic [15:0] Data_from_SRAM0, HEX_data0;
    logic        Ready0, Collision0;

    int checks;
    int failures;

    slc3_mem_responder #(
        .DEPTH_LOG2 (10),
        .WAIT_STATES(2),
        .IO_ADDR    (16'hFFFF)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .ADDR          (ADDR),
        .Data_to_SRAM  (Data_to_SRAM),
        .OE            (OE),
        .WE            (WE),
        .Data_from_SRAM(Data_from_SRAM),
        .Ready         (Ready),
        .SW            (SW),
        .HEX_data      (HEX_data),
        .Collision     (Collision)
    );

    slc3_mem_responder #(
        .DEPTH_LOG2 (10),
        .WAIT_STATES(0),
        .IO_ADDR    (16'hFFFF)
    ) dut0 (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .ADDR          (ADDR0),
        .Data_to_SRAM  (Data_to_SRAM0),
        .OE            (OE0),
        .WE            (WE0),
        .Data_from_SRAM(Data_from_SRAM0),
        .Ready         (Ready0),
        .SW            (SW),
        .HEX_data      (HEX_data0),
        .Collision     (Collision0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one request on the selected DUT and report the cycle index at
    // which Ready is seen (capture cycle = 0), or -1 on timeout.
    task automatic do_req(input bit zw, input bit oe, input bit we,
                          input logic [15:0] addr, input logic [15:0] data,
                          output int lat, output logic [15:0] rd);
        lat = -1;
        rd  = 'x;
        @(negedge Clk);
        if (zw) begin
            OE0 = oe; WE0 = we; ADDR0 = addr; Data_to_SRAM0 = data;
        end else begin
            OE = oe; WE = we; ADDR = addr; Data_to_SRAM = data;
        end
        for (int n = 1; n <= 40; n++) begin
            @(posedge Clk);
            #1;
            if (zw ? Ready0 : Ready) begin
                lat = n;
                rd  = zw ? Data_from_SRAM0 : Data_from_SRAM;
                break;
            end
        end
        @(negedge Clk);
        if (zw) begin
            OE0 = 1'b0; WE0 = 1'b0;
        end else begin
            OE = 1'b0; WE = 1'b0;
        end
        repeat (2) @(posedge Clk);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        #1;
        checks++;
        if (Ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", Ready); end
        checks++;
        if (Data_from_SRAM !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", Data_from_SRAM); end
        checks++;
        if (HEX_data !== 16'h0000) begin failures++; $display("FAIL reset_hex got=%h exp=0000", HEX_data); end
        checks++;
        if (Collision !== 1'b0) begin failures++; $display("FAIL reset_collision got=%b exp=0", Collision); end
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(posedge Clk);
    endtask

    task automatic test_ram_rw();
        int lat;
        logic [15:0] rd;
        do_req(1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, lat, rd);
        checks++;
        if (lat != 4) begin failures++; $display("FAIL rw_write_latency got=%0d exp=4", lat); end
        checks++;
        if (Data_from_SRAM !== 16'h0000) begin failures++; $display("FAIL rw_write_keeps_data got=%h exp=0000", Data_from_SRAM); end
        do_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, lat, rd);
        checks++;
        if (lat != 4) begin failures++; $display("FAIL rw_read_latency got=%0d exp=4", lat); end
        checks++;
        if (rd !== 16'hBEEF) begin failures++; $display("FAIL rw_read_data got=%h exp=beef", rd); end
    endtask

    task automatic test_switch_read();
        int lat;
        logic [15:0] rd;
        SW = 10'h2A5;
        repeat (3) @(posedge Clk);
        do_req(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, lat, rd);
        checks++;
        if (lat != 4) begin failures++; $display("FAIL sw_latency got=%0d exp=4", lat); end
        checks++;
        if (rd !== 16'h02A5) begin failures++; $display("FAIL sw_data got=%h exp=02a5", rd); end
        do_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, lat, rd);
        checks++;
        if (rd !== 16'hBEEF) begin failures++; $display("FAIL sw_ram_unchanged got=%h exp=beef", rd); end
        do_req(1'b0, 1'b1, 1'b0, 16'h0410, 16'h0000, lat, rd);
        checks++;
        if (rd !== 16'hBEEF) begin failures++; $display("FAIL alias_read got=%h exp=beef", rd); end
    endtask

    task automatic test_hex_write();
        int lat;
        logic [15:0] rd;
        do_req(1'b0, 1'b0, 1'b1, 16'h03FF, 16'h5A5A, lat, rd);
        do_req(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h1234, lat, rd);
        checks++;
        if (HEX_data !== 16'h1234) begin failures++; $display("FAIL hex_value got=%h exp=1234", HEX_data); end
        checks++;
        if (Data_from_SRAM !== 16'hBEEF) begin failures++; $display("FAIL hex_keeps_data got=%h exp=beef", Data_from_SRAM); end
        do_req(1'b0, 1'b1, 1'b0, 16'h03FF, 16'h0000, lat, rd);
        checks++;
        if (rd !== 16'h5A5A) begin failures++; $display("FAIL hex_ram_untouched got=%h exp=5a5a", rd); end
    endtask

    task automatic test_held();
        int pulses;
        int lat;
        logic [15:0] rd;
        logic [15:0] seen;
        pulses = 0;
        seen   = 'x;
        @(negedge Clk);
        OE = 1'b1; ADDR = 16'h0010;
        @(posedge Clk);
        @(negedge Clk);
        ADDR = 16'h03FF;
        for (int n = 0; n < 11; n++) begin
            @(posedge Clk);
            #1;
            if (Ready) begin
                pulses++;
                seen = Data_from_SRAM;
            end
        end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
        checks++;
        if (seen !== 16'hBEEF) begin failures++; $display("FAIL held_captured_addr got=%h exp=beef", seen); end
        @(negedge Clk);
        OE = 1'b0;
        repeat (2) @(posedge Clk);
        do_req(1'b0, 1'b1, 1'b0, 16'h03FF, 16'h0000, lat, rd);
        checks++;
        if (lat != 4) begin failures++; $display("FAIL held_next_latency got=%0d exp=4", lat); end
        checks++;
        if (rd !== 16'h5A5A) begin failures++; $display("FAIL held_next_data got=%h exp=5a5a", rd); end
    endtask

    task automatic test_collision();
        int lat;
        logic [15:0] rd;
        do_req(1'b0, 1'b1, 1'b1, 16'h0005, 16'h00AA, lat, rd);
        checks++;
        if (Collision !== 1'b1) begin failures++; $display("FAIL coll_flag got=%b exp=1", Collision); end
        checks++;
        if (Data_from_SRAM !== 16'h5A5A) begin failures++; $display("FAIL coll_is_write got=%h exp=5a5a", Data_from_SRAM); end
        do_req(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, lat, rd);
        checks++;
        if (rd !== 16'h00AA) begin failures++; $display("FAIL coll_readback got=%h exp=00aa", rd); end
        checks++;
        if (Collision !== 1'b1) begin failures++; $display("FAIL coll_sticky got=%b exp=1", Collision); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [15:0] rd;
        do_req(1'b0, 1'b0, 1'b1, 16'h0020, 16'h1111, lat, rd);
        @(negedge Clk);
        WE = 1'b1; ADDR = 16'h0020; Data_to_SRAM = 16'h2222;
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        checks++;
        if (Ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%b exp=0", Ready); end
        checks++;
        if (HEX_data !== 16'h0000) begin failures++; $display("FAIL mid_hex got=%h exp=0000", HEX_data); end
        checks++;
        if (Collision !== 1'b0) begin failures++; $display("FAIL mid_collision got=%b exp=0", Collision); end
        WE = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(posedge Clk);
        checks++;
        if (Ready !== 1'b0) begin failures++; $display("FAIL mid_no_ready got=%b exp=0", Ready); end
        do_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, lat, rd);
        checks++;
        if (lat != 4) begin failures++; $display("FAIL mid_idle_latency got=%0d exp=4", lat); end
        checks++;
        if (rd !== 16'h1111) begin failures++; $display("FAIL mid_write_dropped got=%h exp=1111", rd); end
    endtask

    task automatic test_zero_wait();
        int lat;
        logic [15:0] rd;
        do_req(1'b1, 1'b0, 1'b1, 16'h0030, 16'hCAFE, lat, rd);
        checks++;
        if (lat != 2) begin failures++; $display("FAIL zw_write_latency got=%0d exp=2", lat); end
        do_req(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0000, lat, rd);
        checks++;
        if (lat != 2) begin failures++; $display("FAIL zw_read_latency got=%0d exp=2", lat); end
        checks++;
        if (rd !== 16'hCAFE) begin failures++; $display("FAIL zw_read_data got=%h exp=cafe", rd); end
        do_req(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0000, lat, rd);
        checks++;
        if (rd !== 16'h02A5) begin failures++; $display("FAIL zw_sw_data got=%h exp=02a5", rd); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset_n  = 1'b1;
        SW       = 10'h000;
        OE = 1'b0;  WE = 1'b0;  ADDR = '0;  Data_to_SRAM = '0;
        OE0 = 1'b0; WE0 = 1'b0; ADDR0 = '0; Data_to_SRAM0 = '0;
        #2;
        test_reset();
        test_ram_rw();
        test_switch_read();
        test_hex_write();
        test_held();
        test_collision();
        test_reset_mid();
        test_zero_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
